iot_result_serializer: RTL

Downstream stage of the IoT data-filtering engine. Captures each 128-bit filtered result on its one-cycle `valid` pulse, tags it with the active function code, and queues it in a small FIFO. Emits every queued result as a 17-byte record (header plus 16 data bytes, MSB first) on an 8-bit ready/valid stream toward the byte-wide host link. It absorbs back-to-back results and host backpressure, and flags any result it has to drop.

---
 rtl/iot_result_serializer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/iot_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : iot_result_serializer
// Purpose  : Captures 128-bit filtered results on their one-cycle valid
//            pulse, tags them with the active function code, buffers them in
//            a small FIFO and emits each as a 17-byte record (header byte
//            followed by 16 data bytes, MSB first) on a byte-wide
//            ready/valid stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1    single clock, rising edge
//   rst        in   1    synchronous, active-high reset
//   res_valid  in   1    one-cycle pulse qualifying res_data / res_fn
//   res_data   in   128  filtered result, byte 0 = bits [127:120]
//   res_fn     in   3    function code active for this result
//   out_valid  out  1    out_data holds a byte to transfer
//   out_data   out  8    stream byte
//   out_first  out  1    header byte of a record
//   out_last   out  1    data byte 15 of a record
//   out_ready  in   1    consumer accepts the byte
//   overflow   out  1    sticky: a result was dropped
//   level      out  $clog2(DEPTH)+1  occupied FIFO entries (registered)
// ============================================================================
module iot_result_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     res_valid,
    input  logic [127:0]             res_data,
    input  logic [2:0]               res_fn,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_first,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int                c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL_LEVEL = (c_AW+1)'(DEPTH);
    localparam logic [4:0]        c_HDR_TAG    = 5'b10100;

    // Serializer states
    localparam logic [1:0]        c_ST_IDLE    = 2'd0;
    localparam logic [1:0]        c_ST_HDR     = 2'd1;
    localparam logic [1:0]        c_ST_DATA    = 2'd2;

    // ------------------------------------------------------------------------
    // Storage and bookkeeping
    // ------------------------------------------------------------------------
    // Entry layout: {fn[2:0], data[127:0]}
    logic [130:0]      r_mem [DEPTH];
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_AW:0]     r_level;
    logic [c_AW:0]     w_level_nxt;
    logic              r_overflow;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_bidx;
    logic [3:0]        w_bidx_nxt;

    logic              w_full;
    logic              w_wr;
    logic              w_pop;

    logic [130:0]      w_head;
    logic [2:0]        w_head_fn;
    logic [127:0]      w_head_data;
    logic [127:0]      w_head_shifted;
    logic [7:0]        w_data_byte;

    // Fullness uses the registered level only: a pop in the same cycle does
    // not free a slot for that cycle's write.
    assign w_full = (r_level == c_FULL_LEVEL);
    assign w_wr   = res_valid && !w_full;

    // out_valid is always 1 in DATA, so the pop condition only needs
    // out_ready; this keeps the pop logic independent of the output decode.
    assign w_pop  = (r_state == c_ST_DATA) && (r_bidx == 4'd15) && out_ready;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // FIFO contents carry no reset; only the write-pointer slot is touched,
    // so the head entry is stable while it is being serialized.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {res_fn, res_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level <= w_level_nxt;
            if (res_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign level    = r_level;
    assign overflow = r_overflow;

    // ------------------------------------------------------------------------
    // Head entry byte selection: byte k lives at bits [127-8k -: 8], so
    // shifting left by 8*k brings it to the top byte.
    // ------------------------------------------------------------------------
    assign w_head         = r_mem[r_rptr];
    assign w_head_fn      = w_head[130:128];
    assign w_head_data    = w_head[127:0];
    assign w_head_shifted = w_head_data << {r_bidx, 3'b000};
    assign w_data_byte    = w_head_shifted[127:120];

    // ------------------------------------------------------------------------
    // Serializer FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_bidx  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bidx  <= w_bidx_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Serializer FSM: next state and outputs. Outputs are a pure decode of
    // state/bidx/head, so they hold automatically while out_ready is low.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_bidx_nxt  = r_bidx;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        out_first   = 1'b0;
        out_last    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (r_level != '0) begin
                    w_state_nxt = c_ST_HDR;
                end
            end

            c_ST_HDR: begin
                out_valid = 1'b1;
                out_first = 1'b1;
                out_data  = {c_HDR_TAG, w_head_fn};
                if (out_ready) begin
                    w_state_nxt = c_ST_DATA;
                    w_bidx_nxt  = 4'd0;
                end
            end

            c_ST_DATA: begin
                out_valid = 1'b1;
                out_data  = w_data_byte;
                out_last  = (r_bidx == 4'd15);
                if (out_ready) begin
                    w_bidx_nxt = r_bidx + 4'd1;
                    if (r_bidx == 4'd15) begin
                        // A write landing this cycle counts, giving
                        // back-to-back records with no idle cycle.
                        w_state_nxt = (w_level_nxt != '0) ? c_ST_HDR : c_ST_IDLE;
                        w_bidx_nxt  = 4'd0;
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_bidx_nxt  = 4'd0;
            end
        endcase
    end

endmodule
`default_nettype wire
